// File: rtl/channel_tx_framer.sv
// rtl/channel_tx_framer.sv - transmit framer: SYNC, fixed-length payload, check word, idle fill
//
// Purpose:
//   Takes payload words from a valid/ready source and emits fixed-length
//   frames on the channel bus. Each frame is the SYNC word, PAYLOAD_LEN
//   payload words and then one check word. Between frames the bus carries
//   IDLE_WORD with ch_valid_o low, so the receiver can hunt for SYNC.
//
// Build option:
//   TX_CRC8_EN - when defined, the check word is CRC-8 (poly 0x07, init 0,
//                MSB-first, no reflection, no final XOR). This needs
//                DATA_W=8. When undefined, the check word is the XOR of all
//                payload words.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   in_data       payload word from the source
//   in_valid      in_data valid; in IDLE it only starts a frame
//   in_ready      framer takes in_data this cycle (PAYLOAD state only)
//   ch_data_o     registered channel-bus word
//   ch_valid_o    registered, ch_data_o carries a frame word
//   busy_o        a frame is in progress (state != IDLE)
//   frame_done_o  registered one-cycle pulse alongside the check word
module channel_tx_framer #(
  parameter int                DATA_W      = 8,
  parameter int                PAYLOAD_LEN = 4,
  parameter logic [DATA_W-1:0] SYNC_WORD   = 8'hA5,
  parameter logic [DATA_W-1:0] IDLE_WORD   = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] ch_data_o,
  output logic              ch_valid_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [7:0]        cnt, cnt_n;
  logic [DATA_W-1:0] chk, chk_n;
  logic [DATA_W-1:0] data_n;
  logic              valid_n;
  logic              done_n;

  // Fold one payload word into the running check value.
  function automatic logic [DATA_W-1:0] chk_update(input logic [DATA_W-1:0] c,
                                                   input logic [DATA_W-1:0] d);
`ifdef TX_CRC8_EN
    logic [7:0] r;
    r = c ^ d;
    // Eight unrolled MSB-first shift steps of the 0x07 polynomial.
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
`else
    return c ^ d;
`endif
  endfunction

  assign in_ready = (state == PAYLOAD);
  assign busy_o   = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      chk          <= '0;
      ch_data_o    <= IDLE_WORD;
      ch_valid_o   <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      chk          <= chk_n;
      ch_data_o    <= data_n;
      ch_valid_o   <= valid_n;
      frame_done_o <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    chk_n   = chk;
    data_n  = IDLE_WORD;
    valid_n = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        // in_valid only triggers the frame; the word itself is taken in PAYLOAD.
        if (in_valid) begin
          data_n  = SYNC_WORD;
          valid_n = 1'b1;
          cnt_n   = 8'd0;
          chk_n   = '0;
          state_n = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (in_valid) begin
          data_n  = in_data;
          valid_n = 1'b1;
          chk_n   = chk_update(chk, in_data);
          cnt_n   = cnt + 8'd1;
          if (cnt == 8'(PAYLOAD_LEN - 1)) begin
            state_n = CHECK;
          end
        end
      end
      CHECK: begin
        // chk already folded in the last payload word at its transfer edge.
        data_n  = chk;
        valid_n = 1'b1;
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
